// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: sequences a shared memory port and a reused
// ALU, flags illegal opcodes and counts retired instructions.
// Ports:
//   CLK, Reset (async, active-high), Opcode[5:0], MemReady
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite
//   MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0]
//   PCSource[1:0], SignExtend, ALUop[3:0]
//   InstrDone, IllegalOp, InstrCount[CNT_W-1:0]
module multi_cycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemToReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             SignExtend,
  output logic [3:0]       ALUop,
  output logic             InstrDone,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_MEMADR = 4'h2,
    S_MEMRD  = 4'h3,
    S_MEMWB  = 4'h4,
    S_MEMWR  = 4'h5,
    S_REXEC  = 4'h6,
    S_RWB    = 4'h7,
    S_BRANCH = 4'h8,
    S_JUMP   = 4'h9,
    S_IEXEC  = 4'hA,
    S_IWB    = 4'hB,
    S_TRAP   = 4'hC
  } state_e;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_SLTU = 4'hB;
  localparam logic [3:0] ALU_FN   = 4'hF;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;

  logic       pcw_c, pcwc_c, iord_c, mrd_c, mwr_c, irw_c;
  logic       m2r_c, rdst_c, rw_c, srca_c, sext_c, done_c;
  logic [1:0] srcb_c, pcsrc_c;
  logic [3:0] aluop_c;

  // Immediate-class ALU controls, shared by IEXEC and IWB so the
  // ALU result stays stable through write-back.
  logic [3:0] iop_c;
  logic       isext_c;

  always_comb begin
    iop_c   = ALU_ADD;
    isext_c = 1'b1;
    case (Opcode)
      OP_SLTI:  iop_c = ALU_SLT;
      OP_SLTIU: iop_c = ALU_SLTU;
      OP_ANDI: begin
        iop_c   = ALU_AND;
        isext_c = 1'b0;
      end
      OP_ORI: begin
        iop_c   = ALU_OR;
        isext_c = 1'b0;
      end
      default: iop_c = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pcw_c   = 1'b0;
    pcwc_c  = 1'b0;
    iord_c  = 1'b0;
    mrd_c   = 1'b0;
    mwr_c   = 1'b0;
    irw_c   = 1'b0;
    m2r_c   = 1'b0;
    rdst_c  = 1'b0;
    rw_c    = 1'b0;
    srca_c  = 1'b0;
    srcb_c  = 2'b00;
    pcsrc_c = 2'b00;
    sext_c  = 1'b1;
    aluop_c = ALU_ADD;
    done_c  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mrd_c  = 1'b1;
        srcb_c = 2'b01;
        // IR and PC load only in the cycle memory delivers
        if (MemReady) begin
          irw_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        srcb_c = 2'b11;
        case (Opcode)
          OP_R:     state_d = S_REXEC;
          OP_LW,
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI, OP_ADDIU, OP_SLTI,
          OP_SLTIU, OP_ANDI, OP_ORI:
                    state_d = S_IEXEC;
          default:  state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        srca_c = 1'b1;
        srcb_c = 2'b10;
        if (Opcode == OP_SW) state_d = S_MEMWR;
        else                 state_d = S_MEMRD;
      end
      S_MEMRD: begin
        iord_c = 1'b1;
        mrd_c  = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        m2r_c   = 1'b1;
        rw_c    = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        iord_c = 1'b1;
        mwr_c  = 1'b1;
        if (MemReady) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_REXEC: begin
        srca_c  = 1'b1;
        aluop_c = ALU_FN;
        state_d = S_RWB;
      end
      S_RWB: begin
        rdst_c  = 1'b1;
        rw_c    = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srca_c  = 1'b1;
        aluop_c = ALU_SUB;
        pcwc_c  = 1'b1;
        pcsrc_c = 2'b01;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pcw_c   = 1'b1;
        pcsrc_c = 2'b10;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_IEXEC: begin
        srca_c  = 1'b1;
        srcb_c  = 2'b10;
        aluop_c = iop_c;
        sext_c  = isext_c;
        state_d = S_IWB;
      end
      S_IWB: begin
        srca_c  = 1'b1;
        srcb_c  = 2'b10;
        aluop_c = iop_c;
        sext_c  = isext_c;
        rw_c    = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      if (done_c) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Strobes are masked combinationally so reset silences them at once,
  // even in the middle of a memory access.
  assign PCWrite     = pcw_c  & ~Reset;
  assign PCWriteCond = pcwc_c & ~Reset;
  assign MemRead     = mrd_c  & ~Reset;
  assign MemWrite    = mwr_c  & ~Reset;
  assign IRWrite     = irw_c  & ~Reset;
  assign RegWrite    = rw_c   & ~Reset;
  assign InstrDone   = done_c & ~Reset;
  assign IorD        = iord_c;
  assign MemToReg    = m2r_c;
  assign RegDst      = rdst_c;
  assign ALUSrcA     = srca_c;
  assign ALUSrcB     = srcb_c;
  assign PCSource    = pcsrc_c;
  assign SignExtend  = sext_c;
  assign ALUop       = aluop_c;
  assign IllegalOp   = illegal_q;
  assign InstrCount  = cnt_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed table-driven bench for multi_cycle_control (CNT_W=3).
// Checks every control output and the retire counter cycle by cycle.
module tb_multi_cycle_control;

  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          Reset = 1'b1;
  logic [5:0]    Opcode = 6'd0;
  logic          MemReady = 1'b0;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic          IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]    ALUSrcB, PCSource;
  logic          SignExtend, InstrDone, IllegalOp;
  logic [3:0]    ALUop;
  logic [CW-1:0] InstrCount;

  multi_cycle_control #(.CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .SignExtend(SignExtend), .ALUop(ALUop), .InstrDone(InstrDone),
    .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  always #5 CLK = ~CLK;

  // Bit map: 20 PCWrite 19 PCWriteCond 18 IorD 17 MemRead 16 MemWrite
  // 15 IRWrite 14 MemToReg 13 RegDst 12 RegWrite 11 ALUSrcA
  // 10:9 ALUSrcB 8:7 PCSource 6 SignExtend 5:2 ALUop 1 InstrDone 0 IllegalOp
  logic [20:0] act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
                SignExtend, ALUop, InstrDone, IllegalOp};

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4;
  localparam int S_MW = 5, S_RX = 6, S_RWB = 7, S_BR = 8, S_J = 9;
  localparam int S_IX = 10, S_IWB = 11, S_T = 12;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, SLTIU = 6'b001011;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    string         name;
    logic          rst;
    logic [5:0]    op;
    logic          mr;
    logic [20:0]   exp;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[160];
  int   nv = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [20:0] ev(int st, logic [5:0] op,
                                     logic mr, logic rst);
    logic [20:0] v;
    v = '0;
    v[6] = 1'b1;
    v[5:2] = 4'h2;
    case (st)
      S_F: begin
        v[17] = 1'b1; v[10:9] = 2'b01;
        if (mr) begin v[15] = 1'b1; v[20] = 1'b1; end
      end
      S_D:  v[10:9] = 2'b11;
      S_MA: begin v[11] = 1'b1; v[10:9] = 2'b10; end
      S_MR: begin v[18] = 1'b1; v[17] = 1'b1; end
      S_MWB: begin v[14] = 1'b1; v[12] = 1'b1; v[1] = 1'b1; end
      S_MW: begin v[18] = 1'b1; v[16] = 1'b1; v[1] = mr; end
      S_RX: begin v[11] = 1'b1; v[5:2] = 4'hF; end
      S_RWB: begin v[13] = 1'b1; v[12] = 1'b1; v[1] = 1'b1; end
      S_BR: begin
        v[11] = 1'b1; v[5:2] = 4'h6; v[19] = 1'b1;
        v[8:7] = 2'b01; v[1] = 1'b1;
      end
      S_J: begin v[20] = 1'b1; v[8:7] = 2'b10; v[1] = 1'b1; end
      S_IX, S_IWB: begin
        v[11] = 1'b1; v[10:9] = 2'b10;
        case (op)
          6'b001010: v[5:2] = 4'h7;
          6'b001011: v[5:2] = 4'hB;
          6'b001100: begin v[5:2] = 4'h0; v[6] = 1'b0; end
          6'b001101: begin v[5:2] = 4'h1; v[6] = 1'b0; end
          default:   v[5:2] = 4'h2;
        endcase
        if (st == S_IWB) begin v[12] = 1'b1; v[1] = 1'b1; end
      end
      S_T: v[0] = 1'b1;
      default: v = '0;
    endcase
    if (rst) begin
      v[20] = 1'b0; v[19] = 1'b0; v[17] = 1'b0; v[16] = 1'b0;
      v[15] = 1'b0; v[12] = 1'b0; v[1] = 1'b0; v[0] = 1'b0;
    end
    return v;
  endfunction

  task automatic add(input string nm, input logic r, input logic [5:0] op,
                     input logic mr, input int st, input int c);
    vecs[nv].name = nm;
    vecs[nv].rst  = r;
    vecs[nv].op   = op;
    vecs[nv].mr   = mr;
    vecs[nv].exp  = ev(st, op, mr, r);
    vecs[nv].cnt  = CW'(c);
    nv++;
  endtask

  task automatic run_lat(input string nm, input logic [5:0] op,
                         input int exp_cyc);
    int cyc;
    int irw;
    bit done;
    cyc = 0;
    irw = 0;
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge CLK);
      Opcode = op;
      MemReady = 1'b1;
      #1;
      cyc++;
      if (IRWrite) irw++;
      if (InstrDone) done = 1'b1;
    end
    tests++;
    if (!done || cyc != exp_cyc) begin
      fails++;
      $display("FAIL lat_%s cycles=%0d done=%0b required=%0d",
               nm, cyc, done, exp_cyc);
    end
    tests++;
    if (irw != 1) begin
      fails++;
      $display("FAIL irw_%s pulses=%0d required=1", nm, irw);
    end
  endtask

  initial begin
    add("reset", 1, RT, 0, S_F, 0);
    // lw with FETCH and MEMRD stalls
    add("lw_f0", 0, LW, 0, S_F, 0);
    add("lw_f1", 0, LW, 0, S_F, 0);
    add("lw_f2", 0, LW, 1, S_F, 0);
    add("lw_d",  0, LW, 1, S_D, 0);
    add("lw_ma", 0, LW, 1, S_MA, 0);
    add("lw_mr0", 0, LW, 0, S_MR, 0);
    add("lw_mr1", 0, LW, 0, S_MR, 0);
    add("lw_mr2", 0, LW, 0, S_MR, 0);
    add("lw_mr3", 0, LW, 1, S_MR, 0);
    add("lw_wb", 0, LW, 0, S_MWB, 0);
    // R-type
    add("r_f",  0, RT, 1, S_F, 1);
    add("r_d",  0, RT, 1, S_D, 1);
    add("r_x",  0, RT, 1, S_RX, 1);
    add("r_wb", 0, RT, 1, S_RWB, 1);
    // beq, j
    add("beq_f", 0, BEQ, 1, S_F, 2);
    add("beq_d", 0, BEQ, 1, S_D, 2);
    add("beq_b", 0, BEQ, 1, S_BR, 2);
    add("j_f", 0, JMP, 1, S_F, 3);
    add("j_d", 0, JMP, 1, S_D, 3);
    add("j_j", 0, JMP, 1, S_J, 3);
    // immediates
    add("ori_f",  0, ORI, 1, S_F, 4);
    add("ori_d",  0, ORI, 1, S_D, 4);
    add("ori_x",  0, ORI, 1, S_IX, 4);
    add("ori_wb", 0, ORI, 1, S_IWB, 4);
    add("addi_f",  0, ADDI, 1, S_F, 5);
    add("addi_d",  0, ADDI, 1, S_D, 5);
    add("addi_x",  0, ADDI, 1, S_IX, 5);
    add("addi_wb", 0, ADDI, 1, S_IWB, 5);
    add("sltiu_f",  0, SLTIU, 1, S_F, 6);
    add("sltiu_d",  0, SLTIU, 1, S_D, 6);
    add("sltiu_x",  0, SLTIU, 1, S_IX, 6);
    add("sltiu_wb", 0, SLTIU, 1, S_IWB, 6);
    // sw with one write stall; 8th instruction wraps counter to 0
    add("sw_f",   0, SW, 1, S_F, 7);
    add("sw_d",   0, SW, 1, S_D, 7);
    add("sw_ma",  0, SW, 1, S_MA, 7);
    add("sw_mw0", 0, SW, 0, S_MW, 7);
    add("sw_mw1", 0, SW, 1, S_MW, 7);
    add("andi_f",  0, ANDI, 1, S_F, 0);
    add("andi_d",  0, ANDI, 1, S_D, 0);
    add("andi_x",  0, ANDI, 1, S_IX, 0);
    add("andi_wb", 0, ANDI, 1, S_IWB, 0);
    add("nine_f",  0, SW, 1, S_F, 1);
    // reset in the middle of a store
    add("swr_d",  0, SW, 1, S_D, 1);
    add("swr_ma", 0, SW, 1, S_MA, 1);
    add("swr_mw", 0, SW, 0, S_MW, 1);
    add("swr_rst0", 1, SW, 0, S_F, 0);
    add("swr_rst1", 1, SW, 1, S_F, 0);
    add("swr_rel", 0, SW, 0, S_F, 0);
    // illegal opcode -> sticky trap
    add("bad_f", 0, BAD, 1, S_F, 0);
    add("bad_d", 0, BAD, 1, S_D, 0);
    for (int i = 0; i < 20; i++)
      add($sformatf("trap%0d", i), 0, BAD, i[0], S_T, 0);
    add("trap_rst", 1, BAD, 0, S_F, 0);
    add("trap_rel", 0, RT, 0, S_F, 0);

    for (int i = 0; i < nv; i++) begin
      @(negedge CLK);
      Reset = vecs[i].rst;
      Opcode = vecs[i].op;
      MemReady = vecs[i].mr;
      #1;
      tests++;
      if (act !== vecs[i].exp) begin
        fails++;
        $display("FAIL %s outputs=%h required=%h",
                 vecs[i].name, act, vecs[i].exp);
      end
      tests++;
      if (InstrCount !== vecs[i].cnt) begin
        fails++;
        $display("FAIL %s_cnt InstrCount=%0d required=%0d",
                 vecs[i].name, InstrCount, vecs[i].cnt);
      end
    end

    run_lat("lw", LW, 5);
    run_lat("sw", SW, 4);
    run_lat("r", RT, 4);
    run_lat("addi", ADDI, 4);
    run_lat("beq", BEQ, 3);
    run_lat("j", JMP, 3);
    @(negedge CLK);
    MemReady = 1'b0;
    #1;
    tests++;
    if (InstrCount !== CW'(6)) begin
      fails++;
      $display("FAIL final_cnt InstrCount=%0d required=6", InstrCount);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
